matrix_feeder: RTL

MATRIX_FEEDER -- requirements
Module: matrix_feeder

---
 rtl/matrix_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/matrix_feeder.sv
// matrix_feeder: fetches N vectors from memory one read at a time, then
// streams them into N lanes with a one-cycle skew per lane.
module matrix_feeder #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYS_ARRAY_SIZE = 2,
  parameter int ADDR_WIDTH     = 64
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start_i,
  input  logic [ADDR_WIDTH-1:0]                     base_addr_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      mem_req_o,
  output logic [ADDR_WIDTH-1:0]                     mem_addr_o,
  input  logic                                      mem_gnt_i,
  input  logic                                      mem_rvalid_i,
  input  logic [SYS_ARRAY_SIZE*DATA_WIDTH-1:0]      mem_rdata_i,
  output logic [SYS_ARRAY_SIZE*(DATA_WIDTH+1)-1:0]  feed_o
);

  localparam int N         = SYS_ARRAY_SIZE;
  localparam int VEC_W     = N * DATA_WIDTH;
  localparam int LANE_W    = DATA_WIDTH + 1;
  localparam int VEC_BYTES = VEC_W / 8;
  localparam int K_W       = (N > 1) ? $clog2(N) : 1;
  localparam int S_W       = $clog2(2 * N);

  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(2 * N - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    STREAM
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [K_W-1:0]         k;
  logic [S_W-1:0]         s;
  logic [ADDR_WIDTH-1:0]  base;
  logic [ADDR_WIDTH-1:0]  fetch_offset;
  logic [VEC_W-1:0]       buffer [N];

  // Byte offset of vector k; the add below wraps modulo 2^ADDR_WIDTH.
  assign fetch_offset = ADDR_WIDTH'(k) * ADDR_WIDTH'(VEC_BYTES);

  // State register; reset drops any in-flight read by returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the request-side outputs decoded from state.
  always_comb begin
    next_state = state;
    busy_o     = 1'b1;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          next_state = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base + fetch_offset;
        if (mem_gnt_i) begin
          next_state = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_rvalid_i) begin
          next_state = (k == K_LAST) ? STREAM : FETCH_REQ;
        end
      end
      STREAM: begin
        if (s == S_LAST) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Job bookkeeping: base latched on start, fetch index and stream counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
      k    <= '0;
      s    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            base <= base_addr_i;
            k    <= '0;
            s    <= '0;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid_i && (k != K_LAST)) begin
            k <= k + K_W'(1);
          end
        end
        STREAM: begin
          if (s != S_LAST) begin
            s <= s + S_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Vector buffer; contents are only meaningful after a full fetch phase.
  always_ff @(posedge clk) begin
    if ((state == FETCH_WAIT) && mem_rvalid_i) begin
      buffer[k] <= mem_rdata_i;
    end
  end

  // Done pulses in the first IDLE cycle after the final stream beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o <= 1'b0;
    end else begin
      done_o <= (state == STREAM) && (s == S_LAST);
    end
  end

  // Skewed feed: lane i shows vector s-i, so lane i lags lane 0 by i cycles.
  always_comb begin
    feed_o = '0;
    if (state == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (int'(s) == i + j) begin
            feed_o[i*LANE_W +: LANE_W] = {buffer[j][i*DATA_WIDTH +: DATA_WIDTH], (j == N - 1)};
          end
        end
      end
    end
  end

endmodule
